// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types, funct3 codes and memory-stage enums
package pipeline;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, BUS} mem_state;

  typedef enum logic [1:0] {
    TRAP_NONE       = 2'b00,
    TRAP_MISALIGNED = 2'b01,
    TRAP_BUS_ERR    = 2'b10,
    TRAP_ILLEGAL    = 2'b11
  } trap_cause_t;

  typedef struct packed {
    logic [2:0]      funct3;
    logic            mm_re;
    logic            mm_we;
    logic [XLEN-1:0] mm_addr;
    logic [XLEN-1:0] data;
    logic [4:0]      rd_addr;
  } memory_signals;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd_addr;
  } writeback_signals;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane steering, load extension and access legality
module lsu_align import pipeline::*; (
  input  logic [2:0]      funct3,
  input  logic            mm_re,
  input  logic            mm_we,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            illegal
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = 8'h00;
    case (addr_lo)
      2'd0: lane_byte = rdata[7:0];
      2'd1: lane_byte = rdata[15:8];
      2'd2: lane_byte = rdata[23:16];
      2'd3: lane_byte = rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Stores only encode funct3 000..010; loads additionally reject 011/110/111
  always_comb begin
    illegal = (mm_re && mm_we)
           || (mm_re && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
           || (mm_we && (funct3[2] || funct3 == 3'b011));
    misaligned = (mm_re || mm_we)
              && ((funct3[1:0] == 2'b01 && addr_lo[0])
               || (funct3[1:0] == 2'b10 && addr_lo != 2'b00));
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (mm_we) begin
      case (funct3)
        F3_SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_data = {24'h0, lane_byte};
      F3_LHU:  load_data = {16'h0, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: single-outstanding data bus FSM and writeback/trap registers
module mem_stage import pipeline::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  memory_signals    mem_in,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [XLEN-1:0]  dbus_addr,
  output logic [XLEN-1:0]  dbus_wdata,
  output logic [3:0]       dbus_be,
  input  logic             dbus_ack,
  input  logic             dbus_err,
  input  logic [XLEN-1:0]  dbus_rdata,
  output logic             wb_valid,
  output writeback_signals wb_out,
  output logic             trap_valid,
  output logic [1:0]       trap_cause,
  output logic [XLEN-1:0]  trap_addr
);

  mem_state        state;
  logic [2:0]      f3_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [4:0]      rd_q;

  logic            idle;
  logic [2:0]      al_funct3;
  logic            al_re;
  logic            al_we;
  logic [1:0]      al_addr_lo;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;
  logic            al_misaligned;
  logic            al_illegal;

  assign idle     = (state == IDLE);
  assign in_ready = idle;

  // One aligner serves both phases: the incoming bundle while idle, the latched access while on the bus
  always_comb begin
    al_funct3  = idle ? mem_in.funct3       : f3_q;
    al_re      = idle ? mem_in.mm_re        : !we_q;
    al_we      = idle ? mem_in.mm_we        : we_q;
    al_addr_lo = idle ? mem_in.mm_addr[1:0] : addr_q[1:0];
  end

  lsu_align u_align (
    .funct3     (al_funct3),
    .mm_re      (al_re),
    .mm_we      (al_we),
    .addr_lo    (al_addr_lo),
    .store_data (mem_in.data),
    .rdata      (dbus_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      f3_q       <= 3'b000;
      we_q       <= 1'b0;
      addr_q     <= '0;
      rd_q       <= 5'd0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      dbus_be    <= 4'b0000;
      wb_valid   <= 1'b0;
      wb_out     <= '0;
      trap_valid <= 1'b0;
      trap_cause <= TRAP_NONE;
      trap_addr  <= '0;
    end else begin
      wb_valid   <= 1'b0;
      trap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_in.mm_re && !mem_in.mm_we) begin
              wb_valid <= 1'b1;
              wb_out   <= '{data: mem_in.data, rd_addr: mem_in.rd_addr};
            end else if (al_illegal || al_misaligned) begin
              trap_valid <= 1'b1;
              trap_cause <= al_illegal ? TRAP_ILLEGAL : TRAP_MISALIGNED;
              trap_addr  <= mem_in.mm_addr;
            end else begin
              state      <= BUS;
              f3_q       <= mem_in.funct3;
              we_q       <= mem_in.mm_we;
              addr_q     <= mem_in.mm_addr;
              rd_q       <= mem_in.rd_addr;
              dbus_req   <= 1'b1;
              dbus_we    <= mem_in.mm_we;
              dbus_addr  <= {mem_in.mm_addr[XLEN-1:2], 2'b00};
              dbus_be    <= al_be;
              dbus_wdata <= mem_in.mm_we ? al_wdata : '0;
            end
          end
        end
        BUS: begin
          if (dbus_ack) begin
            state    <= IDLE;
            dbus_req <= 1'b0;
            if (dbus_err) begin
              trap_valid <= 1'b1;
              trap_cause <= TRAP_BUS_ERR;
              trap_addr  <= addr_q;
            end else begin
              wb_valid <= 1'b1;
              wb_out   <= we_q ? '0 : '{data: al_load, rd_addr: rd_q};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
